// File: rtl/traffic_seq.sv
// Highway / farm-road traffic light sequencer with a tick prescaler,
// farm-road demand latch and per-state countdown timer.
module traffic_seq #(
  parameter int MIN_HG = 15,
  parameter int YEL    = 4,
  parameter int MAX_FG = 10,
  parameter int PRESC  = 16
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       FM,
  input  logic       TEST,
  output logic       GRN1,
  output logic       YLW1,
  output logic       RED1,
  output logic       GRN2,
  output logic       YLW2,
  output logic       RED2,
  output logic [1:0] STATE,
  output logic [3:0] TMR
);

  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    FG = 2'b10,
    FY = 2'b11
  } state_e;

  localparam logic [3:0] HG_LD  = 4'(MIN_HG - 1);
  localparam logic [3:0] YEL_LD = 4'(YEL - 1);
  localparam logic [3:0] FG_LD  = 4'(MAX_FG - 1);
  localparam logic [3:0] PC_TOP = 4'(PRESC - 1);

  state_e     state_q, state_d;
  logic [3:0] tmr_q, tmr_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       dem_q, dem_d;
  logic       fml_q, fml_d;
  logic       tick;
  logic       tmr_zero;

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state_q <= HG;
      tmr_q   <= HG_LD;
      pcnt_q  <= '0;
      dem_q   <= 1'b0;
      fml_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pcnt_q  <= pcnt_d;
      dem_q   <= dem_d;
      fml_q   <= fml_d;
    end
  end

  // Prescaler is parked at 0 in fast mode so normal timing restarts cleanly.
  always_comb begin
    pcnt_d = pcnt_q;
    tick   = 1'b0;
    if (TEST) begin
      pcnt_d = '0;
      tick   = 1'b1;
    end else if (pcnt_q == PC_TOP) begin
      pcnt_d = '0;
      tick   = 1'b1;
    end else begin
      pcnt_d = pcnt_q + 4'd1;
    end
  end

  assign fml_d    = FM;
  assign tmr_zero = (tmr_q == 4'd0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (tick) begin
      unique case (state_q)
        HG: if (tmr_zero && dem_q) begin
              state_d = HY;
              tmr_d   = YEL_LD;
            end
        HY: if (tmr_zero) begin
              state_d = FG;
              tmr_d   = FG_LD;
            end
        // Farm green ends early as soon as the farm road is empty.
        FG: if (tmr_zero || !fml_q) begin
              state_d = FY;
              tmr_d   = YEL_LD;
            end
        FY: if (tmr_zero) begin
              state_d = HG;
              tmr_d   = HG_LD;
            end
        default: ;
      endcase
      if (state_d == state_q && !tmr_zero) tmr_d = tmr_q - 4'd1;
    end
  end

  always_comb begin
    dem_d = dem_q;
    if (fml_q && (state_q == HG || state_q == HY)) dem_d = 1'b1;
    if (state_d == FG && state_q != FG) dem_d = 1'b0;
  end

  assign STATE = state_q;
  assign TMR   = tmr_q;
  assign GRN1  = (state_q == HG);
  assign YLW1  = (state_q == HY);
  assign RED1  = (state_q == FG) || (state_q == FY);
  assign GRN2  = (state_q == FG);
  assign YLW2  = (state_q == FY);
  assign RED2  = (state_q == HG) || (state_q == HY);

endmodule

// File: tb/tb_traffic_seq.sv
// Bench for traffic_seq: directed scenarios plus randomized traffic checked
// against an elapsed-tick phase model.
module tb_traffic_seq;
  localparam int MIN_HG = 15;
  localparam int YEL    = 4;
  localparam int MAX_FG = 10;
  localparam int PRESC  = 16;

  logic CK = 1'b0;
  logic CLR, FM, TEST;
  logic GRN1, YLW1, RED1, GRN2, YLW2, RED2;
  logic [1:0] STATE;
  logic [3:0] TMR;
  logic [11:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0..3 = HG,HY,FG,FY; m_el = ticks spent in the phase
  int m_ph, m_el, m_pc;
  bit m_fml, m_dem;

  localparam logic [11:0] RST_VEC = {2'b00, 4'd14, 6'b100001};

  always #5 CK = ~CK;

  traffic_seq #(.MIN_HG(MIN_HG), .YEL(YEL), .MAX_FG(MAX_FG), .PRESC(PRESC)) u_dut (
    .CK(CK), .CLR(CLR), .FM(FM), .TEST(TEST),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .STATE(STATE), .TMR(TMR)
  );

  assign obs = {STATE, TMR, GRN1, YLW1, RED1, GRN2, YLW2, RED2};

  always @(negedge CK) begin
    n_cmp++;
    if (!$onehot({GRN1, YLW1, RED1}) || !$onehot({GRN2, YLW2, RED2}) || (GRN1 && GRN2)) begin
      n_bad++;
      $display("FAIL lamp_excl t=%0t got hwy=%b farm=%b want one-hot, not both green",
               $time, {GRN1, YLW1, RED1}, {GRN2, YLW2, RED2});
    end
  end

  function automatic int dur(input int ph);
    case (ph)
      0: return MIN_HG;
      1: return YEL;
      2: return MAX_FG;
      default: return YEL;
    endcase
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [5:0] lamps;
    case (m_ph)
      0: lamps = 6'b100001;
      1: lamps = 6'b010001;
      2: lamps = 6'b001100;
      default: lamps = 6'b001010;
    endcase
    return {2'(m_ph), 4'(dur(m_ph) - 1 - m_el), lamps};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_pc = 0; m_fml = 0; m_dem = 0;
  endtask

  task automatic model_step();
    bit tk, fin;
    int nph;
    tk   = TEST || (m_pc == PRESC - 1);
    m_pc = TEST ? 0 : (m_pc + 1) % PRESC;
    fin  = (m_el >= dur(m_ph) - 1);
    nph  = m_ph;
    if (tk) begin
      if (m_ph == 0 && fin && m_dem) nph = 1;
      else if (m_ph == 1 && fin) nph = 2;
      else if (m_ph == 2 && (fin || !m_fml)) nph = 3;
      else if (m_ph == 3 && fin) nph = 0;
    end
    if (m_fml && m_ph < 2) m_dem = 1;
    if (nph == 2 && m_ph != 2) m_dem = 0;
    if (nph != m_ph) m_el = 0;
    else if (tk && !fin) m_el++;
    m_ph  = nph;
    m_fml = FM;
  endtask

  task automatic step();
    @(posedge CK);
    model_step();
    #1;
  endtask

  task automatic clr_on();
    CLR = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic clr_off();
    @(posedge CK);
    #2;
    CLR = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b1; FM = 1'b0; TEST = 1'b1;
    #2;
    model_reset();
    n_cmp++;
    if (obs !== RST_VEC) begin
      n_bad++; $display("FAIL reset_during got %h want %h", obs, RST_VEC);
    end
    clr_off();
    n_cmp++;
    if (obs !== RST_VEC) begin
      n_bad++; $display("FAIL reset_after got %h want %h", obs, RST_VEC);
    end
  endtask

  task automatic test_fast_sequence();
    int es;
    clr_on(); FM = 1'b1; TEST = 1'b1; clr_off();
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) step();
      es = (k < 15) ? 0 : (k < 19) ? 1 : (k < 29) ? 2 : (k < 33) ? 3 : 0;
      n_cmp++;
      if (STATE !== 2'(es)) begin
        n_bad++; $display("FAIL fast_state k=%0d got %0d want %0d", k, STATE, es);
      end
      if (k < 15) begin
        n_cmp++;
        if (TMR !== 4'(14 - k)) begin
          n_bad++; $display("FAIL fast_tmr k=%0d got %0d want %0d", k, TMR, 14 - k);
        end
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL fast_model k=%0d got %h want %h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_no_demand();
    int et;
    clr_on(); FM = 1'b0; TEST = 1'b1; clr_off();
    for (int k = 0; k < 100; k++) begin
      if (k > 0) step();
      et = (k < 14) ? 14 - k : 0;
      n_cmp++;
      if (STATE !== 2'b00 || TMR !== 4'(et) || GRN1 !== 1'b1) begin
        n_bad++; $display("FAIL no_demand k=%0d got st=%0d tmr=%0d g1=%b want st=0 tmr=%0d g1=1",
                          k, STATE, TMR, GRN1, et);
      end
    end
  endtask

  task automatic test_pulse_demand();
    clr_on(); FM = 1'b0; TEST = 1'b1; clr_off();
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) step();
      FM = (k == 3);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL pulse_model k=%0d got %h want %h", k, obs, exp_vec());
      end
      if (k == 14 || k == 15) begin
        n_cmp++;
        if (STATE !== ((k == 14) ? 2'b00 : 2'b01)) begin
          n_bad++; $display("FAIL pulse_hy k=%0d got %0d want %0d", k, STATE, (k == 14) ? 0 : 1);
        end
      end
    end
    FM = 1'b0;
  endtask

  task automatic test_early_release();
    int g2;
    g2 = 0;
    clr_on(); FM = 1'b1; TEST = 1'b1; clr_off();
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) step();
      if (k == 22) FM = 1'b0;
      if (GRN2) g2++;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL early_model k=%0d got %h want %h", k, obs, exp_vec());
      end
      if (k == 23 || k == 24) begin
        n_cmp++;
        if (STATE !== ((k == 23) ? 2'b10 : 2'b11)) begin
          n_bad++; $display("FAIL early_fy k=%0d got %0d want %0d", k, STATE, (k == 23) ? 2 : 3);
        end
      end
    end
    n_cmp++;
    if (g2 != 5) begin
      n_bad++; $display("FAIL early_grn2_len got %0d want 5", g2);
    end
  endtask

  task automatic test_normal_timing();
    int hg;
    hg = 0;
    clr_on(); FM = 1'b1; TEST = 1'b0; clr_off();
    for (int k = 0; k <= 310; k++) begin
      if (k > 0) step();
      if (GRN1 && k < 300) hg++;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL normal_model k=%0d got %h want %h", k, obs, exp_vec());
      end
      if (k == 239 || k == 240 || k == 303 || k == 304) begin
        n_cmp++;
        if (STATE !== ((k == 239) ? 2'd0 : (k == 304) ? 2'd2 : 2'd1)) begin
          n_bad++; $display("FAIL normal_edge k=%0d got %0d", k, STATE);
        end
      end
    end
    n_cmp++;
    if (hg != 240) begin
      n_bad++; $display("FAIL normal_hg_len got %0d want 240", hg);
    end
  endtask

  task automatic test_test_toggle();
    logic [3:0] t0;
    clr_on(); FM = 1'b0; TEST = 1'b0; clr_off();
    for (int k = 0; k < 5; k++) step();
    TEST = 1'b1;
    for (int k = 0; k < 3; k++) step();
    TEST = 1'b0;
    t0 = TMR;
    n_cmp++;
    if (t0 !== 4'd11) begin
      n_bad++; $display("FAIL toggle_fast got %0d want 11", t0);
    end
    for (int k = 0; k < 15; k++) step();
    n_cmp++;
    if (TMR !== 4'd11 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL toggle_hold got %0d want 11", TMR);
    end
    step();
    n_cmp++;
    if (TMR !== 4'd10 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL toggle_tick got %0d want 10", TMR);
    end
  endtask

  task automatic test_clear_mid_fg();
    clr_on(); FM = 1'b1; TEST = 1'b1; clr_off();
    for (int k = 1; k <= 21; k++) step();
    n_cmp++;
    if (STATE !== 2'b10) begin
      n_bad++; $display("FAIL clr_pre_fg got %0d want 2", STATE);
    end
    #2;
    clr_on();
    n_cmp++;
    if (obs !== RST_VEC || u_dut.dem_q !== 1'b0) begin
      n_bad++; $display("FAIL clr_async got %h dem=%b want %h dem=0", obs, u_dut.dem_q, RST_VEC);
    end
    FM = 1'b0;
    clr_off();
    step();
    n_cmp++;
    if (TMR !== 4'd13 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL clr_restart got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    clr_on(); FM = 1'b0; TEST = 1'b1; clr_off();
    for (int k = 0; k < 600; k++) begin
      FM = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) TEST = ~TEST;
      if ($urandom_range(0, 149) == 0) begin
        clr_on();
        n_cmp++;
        if (obs !== RST_VEC) begin
          n_bad++; $display("FAIL rand_clr k=%0d got %h want %h", k, obs, RST_VEC);
        end
        clr_off();
      end
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL rand_model k=%0d got %h want %h", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_sequence();
    test_no_demand();
    test_pulse_demand();
    test_early_release();
    test_normal_timing();
    test_test_toggle();
    test_clear_mid_fg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_seq.md
TRAFFIC_SEQ -- requirements
Module: traffic_seq

Interface
REQ-001 Parameter MIN_HG, default 15: highway-green minimum, in ticks (1..16).
REQ-002 Parameter YEL, default 4: yellow duration, in ticks (1..16).
REQ-003 Parameter MAX_FG, default 10: farm-green maximum, in ticks (1..16).
REQ-004 Parameter PRESC, default 16: clock cycles per tick in normal mode (2..16).
REQ-005 CK  input  1  single clock; all state changes on rising edge.
REQ-006 CLR  input  1  reset, asynchronous, active-high.
REQ-007 FM  input  1  farm-road vehicle sensor, asynchronous to nothing (synchronous to CK by system).
REQ-008 TEST  input  1  fast-timing mode: one tick per CK cycle.
REQ-009 GRN1, YLW1, RED1  output  1 each  highway lamps.
REQ-010 GRN2, YLW2, RED2  output  1 each  farm-road lamps.
REQ-011 STATE  output  2  current state encoding: HG=00, HY=01, FG=10, FY=11.
REQ-012 TMR  output  4  current state timer value.

Function
REQ-013 FML SHALL be a one-cycle registered copy of FM; all decisions use FML, never FM directly.
REQ-014 Prescaler PCNT (4 bits) SHALL count 0..PRESC-1 and wrap; tick = (PCNT==PRESC-1) when TEST=0.
REQ-015 When TEST=1, tick SHALL be asserted every cycle and PCNT held at 0; on TEST falling, PCNT resumes from 0.
REQ-016 Demand latch DEM SHALL set on any cycle with FML=1 while STATE is HG or HY, and clear on the edge entering FG; set has no effect in FG/FY.
REQ-017 State entry SHALL load TMR with (duration-1): HG<-MIN_HG-1, HY<-YEL-1, FG<-MAX_FG-1, FY<-YEL-1.
REQ-018 On a tick with TMR!=0 and no transition, TMR SHALL decrement by 1; TMR never wraps below 0; no tick -> TMR holds.
REQ-019 HG: on tick with TMR==0 and DEM=1 -> HY; with DEM=0, stay HG, TMR held at 0 indefinitely.
REQ-020 HY: on tick with TMR==0 -> FG.
REQ-021 FG: on tick with TMR==0 or FML==0 -> FY (early release when farm road empties); else decrement.
REQ-022 FY: on tick with TMR==0 -> HG.
REQ-023 Transitions SHALL occur only on ticks; no state is skipped; exactly one transition per tick maximum.
REQ-024 Lamp decode from STATE register (no extra latency): GRN1=HG, YLW1=HY, RED1=FG|FY, GRN2=FG, YLW2=FY, RED2=HG|HY.
REQ-025 Exactly one lamp per road SHALL be on every cycle; GRN1 and GRN2 never both 1.

Reset
REQ-026 CLR=1 SHALL immediately (asynchronously) force STATE=HG, TMR=MIN_HG-1, PCNT=0, DEM=0, FML=0.
REQ-027 Outputs during/after reset: GRN1=1, RED2=1, all other lamps 0, STATE=00, TMR=MIN_HG-1.
REQ-028 CLR asserted mid-sequence (any state) SHALL abandon it; first tick after release counts from MIN_HG-1 in HG.

Verification
REQ-029 TEST=1, FM=1 held from reset release -> GRN1 for 15 cycles, YLW1 4, GRN2 10, YLW2 4, then GRN1 again; TMR sequence 14..0 in HG.
REQ-030 TEST=1, FM=0 for 100 cycles -> STATE stays 00, TMR=0 from cycle 15 on, GRN1=1 throughout.
REQ-031 TEST=1, single-cycle FM pulse at cycle 3 -> DEM held; HY entered on cycle 15 exactly as REQ-029.
REQ-032 TEST=1, FM drops at FG cycle 3 -> FML low next cycle, FY on following tick; GRN2 lasts 5 cycles, not 10.
REQ-033 TEST=0, PRESC=16, FM=1 -> HG lasts 15*16=240 cycles, HY 64 cycles; toggling TEST mid-HG restarts PCNT at 0.
REQ-034 CLR pulsed (1 cycle, async to edge) during FG -> outputs immediately GRN1=1, RED2=1, TMR=14, DEM=0; lamp exclusivity (REQ-025) asserted every cycle in all scenarios.
